// File: rtl/booth_pkg.sv
// Shared radix-4 Booth definitions: digit codes, decoder state encoding and
// the legal-code predicate used by the optional illegal-digit checker.
package booth_pkg;

  localparam logic [2:0] BOOTH4_ZERO = 3'b000;
  localparam logic [2:0] BOOTH4_POS1 = 3'b001;
  localparam logic [2:0] BOOTH4_POS2 = 3'b010;
  localparam logic [2:0] BOOTH4_NEG2 = 3'b110;
  localparam logic [2:0] BOOTH4_NEG1 = 3'b111;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } dec_state_e;

  // 011, 100 and 101 can never come out of a radix-4 recoder.
  function automatic logic booth4_is_legal(input logic [2:0] digit);
    return (digit == BOOTH4_ZERO) || (digit == BOOTH4_POS1) ||
           (digit == BOOTH4_POS2) || (digit == BOOTH4_NEG2) ||
           (digit == BOOTH4_NEG1);
  endfunction

endpackage

// File: rtl/booth4_digit_weight.sv
// Combinational weight of one Booth digit: sign-extend the 3-bit digit to
// WIDTH bits and scale by 4^idx, dropping anything shifted past the top bit.
module booth4_digit_weight #(
  parameter int WIDTH = 16,
  parameter int CW    = 3
) (
  input  logic [2:0]       digit,
  input  logic [CW-1:0]    idx,
  output logic [WIDTH-1:0] term
);

  logic [WIDTH-1:0] sext;

  assign sext = {{(WIDTH-3){digit[2]}}, digit};
  assign term = sext << {idx, 1'b0};

endmodule

// File: rtl/booth4_digit_decoder.sv
// Rebuilds a WIDTH-bit two's-complement operand from a LSD-first stream of
// radix-4 Booth digits. Optional illegal-digit flag: BOOTH_DEC_ERR_CHECK_EN.
// Handshake: a transfer occurs on a rising edge where valid && ready; in_ready
// and out_valid depend only on state, never combinationally on the other side.
module booth4_digit_decoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_digit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value
`ifdef BOOTH_DEC_ERR_CHECK_EN
  ,
  output logic             out_err
`endif
);

  localparam int NDIG = WIDTH / 2;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  dec_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] sum;

  booth4_digit_weight #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_weight (
    .digit (in_digit),
    .idx   (cnt_q),
    .term  (term)
  );

  assign sum       = acc_q + term;
  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_value = value_q;

`ifdef BOOTH_DEC_ERR_CHECK_EN
  logic err_q, err_d;
  assign out_err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    value_d = value_q;
`ifdef BOOTH_DEC_ERR_CHECK_EN
    err_d   = err_q;
`endif
    // flush overrides everything, including a coincident output handshake
    if (flush) begin
      state_d = COLLECT;
      acc_d   = '0;
      cnt_d   = '0;
`ifdef BOOTH_DEC_ERR_CHECK_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            acc_d = sum;
`ifdef BOOTH_DEC_ERR_CHECK_EN
            err_d = err_q | ~booth4_is_legal(in_digit);
`endif
            if (cnt_q == LAST_IDX) begin
              state_d = HOLD;
              cnt_d   = '0;
              value_d = sum;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = COLLECT;
            acc_d   = '0;
`ifdef BOOTH_DEC_ERR_CHECK_EN
            err_d   = 1'b0;
`endif
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
`ifdef BOOTH_DEC_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
`ifdef BOOTH_DEC_ERR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_booth4_digit_decoder.sv
// Self-checking bench for booth4_digit_decoder (WIDTH=16): directed vectors,
// backpressure, flush, async reset and randomized recoded operands.
module tb_booth4_digit_decoder;

  localparam int WIDTH = 16;
  localparam int NDIG  = WIDTH / 2;

  typedef logic [2:0] word_t [NDIG];

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_digit;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
`ifdef BOOTH_DEC_ERR_CHECK_EN
  logic             out_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  booth4_digit_decoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value)
`ifdef BOOTH_DEC_ERR_CHECK_EN
    ,
    .out_err   (out_err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: sum of signed digit * 4^i, reduced mod 2^WIDTH
  function automatic logic [WIDTH-1:0] model_value(input word_t d);
    int acc = 0;
    int w = 1;
    int sd;
    for (int i = 0; i < NDIG; i++) begin
      sd = int'(d[i]);
      if (d[i][2]) sd = sd - 8;
      acc = acc + sd * w;
      w = w * 4;
    end
    return WIDTH'(acc);
  endfunction

  // radix-4 Booth recoder: digit_i = -2*b[2i+1] + b[2i] + b[2i-1], b[-1]=0
  function automatic word_t recode(input logic [WIDTH-1:0] v);
    word_t d;
    logic prev = 1'b0;
    int val;
    for (int i = 0; i < NDIG; i++) begin
      val = -2 * int'(v[2*i+1]) + int'(v[2*i]) + int'(prev);
      prev = v[2*i+1];
      d[i] = 3'(val);
    end
    return d;
  endfunction

  // drivers: all tasks start and end at posedge + #1
  task automatic send_digit(input logic [2:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_digit = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_digit = 3'($urandom);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_digit_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic send_word(input word_t d, input int gap_max);
    for (int i = 0; i < NDIG; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_digit = 3'($urandom);
        @(posedge clk); #1;
      end
      send_digit(d[i]);
    end
  endtask

  // leaves the caller at a negedge with out_valid sampled
  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_digit = 3'b000; out_ready = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_value !== '0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%0b out_valid=%0b out_value=%h required 1 0 0000",
               in_ready, out_valid, out_value);
    end
`ifdef BOOTH_DEC_ERR_CHECK_EN
    checks++;
    if (out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: out_err=%0b required 0", out_err);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    word_t vec[4];
    logic [WIDTH-1:0] exp;
    bit got;
    vec[0] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    vec[1] = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    vec[2] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b110};
    vec[3] = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(model_value(vec[v]));
      send_word(vec[v], 0);
      // last accept happened at the previous edge: result must be visible now
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_value !== exp) begin
        errors++;
        $display("FAIL vector%0d_result: out_valid=%0b in_ready=%0b out_value=%h required 1 0 %h",
                 v, out_valid, in_ready, out_value, exp);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL vector%0d_one_cycle: out_valid=%0b in_ready=%0b required 0 1",
                 v, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    got = 1'b1;
  endtask

  task automatic test_backpressure;
    word_t w5, wff;
    logic [WIDTH-1:0] exp;
    bit got;
    bit stable = 1'b1;
    w5  = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    wff = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    out_ready = 1'b0;
    exp_q.push_back(model_value(w5));
    send_word(w5, 1);
    wait_valid(got);
    exp = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_digit = 3'b001;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_value !== exp) stable = 1'b0;
    end
    checks++;
    if (!got || !stable) begin
      errors++;
      $display("FAIL backpressure_hold: out_valid=%0b in_ready=%0b out_value=%h required 1 0 %h",
               out_valid, in_ready, out_value, exp);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%0b in_ready=%0b required 0 1",
               out_valid, in_ready);
    end
    @(posedge clk); #1;
    exp_q.push_back(model_value(wff));
    send_word(wff, 0);
    wait_valid(got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || out_value !== exp) begin
      errors++;
      $display("FAIL backpressure_next_word: out_value=%h required %h", out_value, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    word_t w5, wr;
    logic [WIDTH-1:0] exp;
    bit got;
    bit leaked = 1'b0;
    w5 = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    out_ready = 1'b1;
    send_digit(3'b111);
    send_digit(3'b010);
    send_digit(3'b001);
    flush = 1'b1; in_valid = 1'b1; in_digit = 3'b001;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_midword_state: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    exp_q.push_back(model_value(w5));
    send_word(w5, 0);
    wait_valid(got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || out_value !== exp) begin
      errors++;
      $display("FAIL flush_no_residue: out_value=%h required %h", out_value, exp);
    end
    @(posedge clk); #1;
    // flush while holding a result, with out_ready high in the same cycle
    out_ready = 1'b0;
    send_word(recode(16'h1234), 0);
    wait_valid(got);
    @(posedge clk); #1;
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) leaked = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!got || leaked) begin
      errors++;
      $display("FAIL flush_in_hold: got=%0b out_valid=%0b seen after flush, required 0", got, leaked);
    end
    wr = recode(16'hA5C3);
    exp_q.push_back(model_value(wr));
    send_word(wr, 0);
    wait_valid(got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || out_value !== exp) begin
      errors++;
      $display("FAIL flush_hold_next_word: out_value=%h required %h", out_value, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midword;
    word_t wr;
    logic [WIDTH-1:0] exp;
    bit got;
    out_ready = 1'b1;
    send_digit(3'b111);
    send_digit(3'b001);
    send_digit(3'b110);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_value !== '0) begin
      errors++;
      $display("FAIL reset_midword: in_ready=%0b out_valid=%0b out_value=%h required 1 0 0000",
               in_ready, out_valid, out_value);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    wr = recode(16'h0F0F);
    exp_q.push_back(model_value(wr));
    send_word(wr, 0);
    wait_valid(got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || out_value !== exp) begin
      errors++;
      $display("FAIL reset_midword_next: out_value=%h required %h", out_value, exp);
    end
    // async reset while holding a result
    out_ready = 1'b0;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_value !== '0) begin
      errors++;
      $display("FAIL reset_in_hold: in_ready=%0b out_valid=%0b out_value=%h required 1 0 0000",
               in_ready, out_valid, out_value);
    end
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef BOOTH_DEC_ERR_CHECK_EN
  task automatic test_err_check;
    word_t wbad, w5;
    logic [WIDTH-1:0] exp;
    bit got;
    wbad = '{3'b001, 3'b001, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    w5   = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    out_ready = 1'b1;
    exp_q.push_back(model_value(wbad));
    send_word(wbad, 1);
    wait_valid(got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || out_err !== 1'b1 || out_value !== exp) begin
      errors++;
      $display("FAIL err_illegal_digit: out_err=%0b out_value=%h required 1 %h", out_err, out_value, exp);
    end
    @(posedge clk); #1;
    exp_q.push_back(model_value(w5));
    send_word(w5, 0);
    wait_valid(got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || out_err !== 1'b0 || out_value !== exp) begin
      errors++;
      $display("FAIL err_clean_word: out_err=%0b out_value=%h required 0 %h", out_err, out_value, exp);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_word(wbad, 0);
    wait_valid(got);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (!got || out_err !== 1'b0) begin
      errors++;
      $display("FAIL err_flush_clear: out_err=%0b required 0", out_err);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_random;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] exp;
    bit got;
    int bad = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      op = WIDTH'($urandom);
      exp_q.push_back(op);
      send_word(recode(op), 1);
      wait_valid(got);
      exp = exp_q.pop_front();
      checks++;
      if (!got || out_value !== exp) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_word%0d: out_value=%h required %h", k, out_value, exp);
        bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_flush();
    test_reset_midword();
`ifdef BOOTH_DEC_ERR_CHECK_EN
    test_err_check();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
